// File: rtl/dmem_pkg.sv
// dmem_pkg: shared states, access-size encodings and alignment rule for the data-memory controller
package dmem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  // Reserved size is treated as a fault so it never touches memory.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b11) || (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian lane merge for sub-word stores and lane extract for loads
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);
  logic [4:0]  w_sh;
  logic [31:0] w_mask;
  logic [15:0] w_h;
  logic [7:0]  w_b;
  assign w_sh     = {i_addr, 3'b000};
  assign w_mask   = (i_size == SZ_BYTE ? 32'h0000_00ff : i_size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff) << w_sh;
  assign o_merged = (i_word & ~w_mask) | ((i_wdata << w_sh) & w_mask);
  assign w_h      = 16'(i_word >> w_sh);
  assign w_b      = w_h[7:0];
  assign o_load   = i_size == SZ_BYTE ? {{24{i_sext & w_b[7]}}, w_b} :
                    i_size == SZ_HALF ? {{16{i_sext & w_h[15]}}, w_h} : i_word;
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage load/store sequencer with read-modify-write for sub-word stores
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] m_addr,
  output logic [31:0] m_datain,
  output logic        m_we,
  input  logic [31:0] m_dataout
);
  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_wr, r_sext, r_we, r_rvalid, r_misalign;
  logic [1:0]  r_size, r_lane;
  logic [31:0] r_wdata, r_line, r_maddr, r_datain, r_rdata;
  logic [31:0] w_word, w_merged, w_load;

  // Memory word is used live in the capture cycle so merge/extract results register on the same edge.
  assign w_word   = (r_state == ST_RD) ? m_dataout : r_line;
  assign stall    = req & (r_state != ST_DONE);
  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;
  assign misalign = r_misalign;
  assign m_addr   = r_maddr;
  assign m_datain = r_datain;
  assign m_we     = r_we;

  dmem_lane_align u_lane (
    .i_word  (w_word),
    .i_addr  (r_lane),
    .i_size  (r_size),
    .i_sext  (r_sext),
    .i_wdata (r_wdata),
    .o_merged(w_merged),
    .o_load  (w_load)
  );

  // Access FSM; every output is registered on the transition into the state that presents it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_wr       <= 1'b0;
      r_sext     <= 1'b0;
      r_size     <= SZ_BYTE;
      r_lane     <= 2'b00;
      r_wdata    <= 32'd0;
      r_line     <= 32'd0;
      r_maddr    <= 32'd0;
      r_datain   <= 32'd0;
      r_rdata    <= 32'd0;
      r_we       <= 1'b0;
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: if (req) begin
          r_wr    <= wr;
          r_size  <= size;
          r_sext  <= sext;
          r_lane  <= addr[1:0];
          r_wdata <= wdata;
          r_maddr <= {addr[31:2], 2'b00};
          if (misaligned(size, addr[1:0])) begin
            r_state    <= ST_DONE;
            r_rvalid   <= 1'b1;
            r_misalign <= 1'b1;
            r_rdata    <= 32'd0;
          end else if (wr && size == SZ_WORD) begin
            r_state  <= ST_WR;
            r_we     <= 1'b1;
            r_datain <= wdata;
          end else begin
            r_state <= ST_RD;
            r_cnt   <= 3'(WAIT_CYCLES);
          end
        end
        ST_RD: if (r_cnt != 3'd0) begin
          r_cnt <= r_cnt - 3'd1;
        end else begin
          r_line <= m_dataout;
          if (r_wr) begin
            r_state  <= ST_WR;
            r_we     <= 1'b1;
            r_datain <= w_merged;
          end else begin
            r_state    <= ST_DONE;
            r_rvalid   <= 1'b1;
            r_misalign <= 1'b0;
            r_rdata    <= w_load;
          end
        end
        ST_WR: begin
          r_state    <= ST_DONE;
          r_rvalid   <= 1'b1;
          r_misalign <= 1'b0;
          r_rdata    <= 32'd0;
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          r_rvalid <= 1'b0;
          r_maddr  <= 32'd0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: random and directed load/store traffic against a transaction-level model, W=0 and W=2 instances
module tb_dmem_access_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  clrn, req, wr, sext, stall, rvalid, misalign, m_we;
  logic [1:0]  size [2];
  logic [31:0] addr [2], wdata [2], rdata [2], m_addr [2], m_datain [2], m_dataout [2];
  logic [31:0] mem [2][64];
  logic [31:0] refm [2][64];
  logic [31:0] exp_wa [2], exp_wd [2], last_wa [2], last_wd [2];
  bit   [1:0]  pend;
  bit          loaded;
  int          vectors = 0, miscompares = 0;

  dmem_access_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .clrn(clrn[0]), .req(req[0]), .wr(wr[0]), .size(size[0]), .sext(sext[0]),
    .addr(addr[0]), .wdata(wdata[0]), .stall(stall[0]), .rvalid(rvalid[0]), .rdata(rdata[0]),
    .misalign(misalign[0]), .m_addr(m_addr[0]), .m_datain(m_datain[0]), .m_we(m_we[0]),
    .m_dataout(m_dataout[0]));

  dmem_access_ctrl #(.WAIT_CYCLES(2)) dut1 (
    .clk(clk), .clrn(clrn[1]), .req(req[1]), .wr(wr[1]), .size(size[1]), .sext(sext[1]),
    .addr(addr[1]), .wdata(wdata[1]), .stall(stall[1]), .rvalid(rvalid[1]), .rdata(rdata[1]),
    .misalign(misalign[1]), .m_addr(m_addr[1]), .m_datain(m_datain[1]), .m_we(m_we[1]),
    .m_dataout(m_dataout[1]));

  function automatic logic [31:0] init_val(input int i);
    case (i)
      20: return 32'h0000_00a3;
      21: return 32'h0000_0027;
      22: return 32'h0000_0079;
      23: return 32'h0000_0115;
      default: return 32'(32'h9e37_79b9 * i);
    endcase
  endfunction

  // Word-wide memory: combinational read, write on posedge.
  assign m_dataout[0] = mem[0][m_addr[0][7:2]];
  assign m_dataout[1] = mem[1][m_addr[1][7:2]];
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) begin
        mem[0][i] <= init_val(i);
        mem[1][i] <= init_val(i);
      end
      loaded <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++)
        if (m_we[d]) mem[d][m_addr[d][7:2]] <= m_datain[d];
    end
  end

  function automatic logic is_mis(input logic [1:0] sz, input logic [1:0] a);
    return sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
  endfunction

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] a, input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    if (sz == 2'd0) begin
      b = w[8*a +: 8];
      return sx ? {{24{b[7]}}, b} : {24'd0, b};
    end
    if (sz == 2'd1) begin
      h = a[1] ? w[31:16] : w[15:0];
      return sx ? {{16{h[15]}}, h} : {16'd0, h};
    end
    return w;
  endfunction

  function automatic logic [31:0] st_model(input logic [31:0] w, input logic [1:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    if (sz == 2'd0) r[8*a +: 8] = wd[7:0];
    else if (sz == 2'd1) r[16*a[1] +: 16] = wd[15:0];
    else r = wd;
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Per-cycle checks on both instances: stall rule and every memory write against the model's pending write.
  task automatic sample();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("stall%0d", d), {31'd0, stall[d]}, {31'd0, req[d] & ~rvalid[d]});
      if (m_we[d]) begin
        chk($sformatf("we_expected%0d", d), {31'd0, pend[d]}, 32'd1);
        chk($sformatf("we_addr%0d", d), m_addr[d], exp_wa[d]);
        chk($sformatf("we_data%0d", d), m_datain[d], exp_wd[d]);
        pend[d]  = 1'b0;
        last_wa[d] = m_addr[d];
        last_wd[d] = m_datain[d];
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_outputs_zero(input int d);
    chk($sformatf("rst_rvalid%0d", d), {31'd0, rvalid[d]}, 32'd0);
    chk($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
    chk($sformatf("rst_misalign%0d", d), {31'd0, misalign[d]}, 32'd0);
    chk($sformatf("rst_m_we%0d", d), {31'd0, m_we[d]}, 32'd0);
    chk($sformatf("rst_m_addr%0d", d), m_addr[d], 32'd0);
    chk($sformatf("rst_m_datain%0d", d), m_datain[d], 32'd0);
  endtask

  // One access from the request cycle to rvalid; called at posedge+1.
  task automatic do_op(input int d, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input bit drop,
                       output int lat, output logic [31:0] rd, output logic mis);
    int          wc, el;
    logic [31:0] erd, old;
    logic        emis;
    wc   = d ? 2 : 0;
    old  = refm[d][a[7:2]];
    emis = is_mis(sz, a[1:0]);
    erd  = 32'd0;
    if (emis) el = 2;
    else if (w) begin
      el = (sz == 2'd2) ? 3 : 4 + wc;
      exp_wa[d] = {a[31:2], 2'b00};
      exp_wd[d] = st_model(old, a[1:0], sz, wd);
      refm[d][a[7:2]] = exp_wd[d];
      pend[d] = 1'b1;
    end else begin
      el  = 3 + wc;
      erd = ld_model(old, a[1:0], sz, sx);
    end
    req[d] = 1'b1; wr[d] = w; size[d] = sz; sext[d] = sx; addr[d] = a; wdata[d] = wd;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      sample();
      if (rvalid[d]) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
      if (drop) req[d] = 1'b0;
      wr[d] = $urandom_range(0, 1); addr[d] = $urandom; wdata[d] = $urandom;
    end
    rd  = rdata[d];
    mis = misalign[d];
    @(posedge clk);
    #1;
    req[d] = 1'b0;
    chk($sformatf("latency%0d", d), lat, el);
    chk($sformatf("rdata%0d", d), rd, erd);
    chk($sformatf("misalign%0d", d), {31'd0, mis}, {31'd0, emis});
    chk($sformatf("write_seen%0d", d), {31'd0, pend[d]}, 32'd0);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        mis;

  initial begin
    clrn = 2'b00; req = 2'b00; wr = 2'b00; sext = 2'b00; pend = 2'b00;
    for (int d = 0; d < 2; d++) begin
      size[d] = 2'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
      exp_wa[d] = 32'd0; exp_wd[d] = 32'd0; last_wa[d] = 32'd0; last_wd[d] = 32'd0;
      for (int i = 0; i < 64; i++) refm[d][i] = init_val(i);
    end
    repeat (3) @(negedge clk);
    reset_outputs_zero(0);
    reset_outputs_zero(1);
    @(posedge clk);
    #1;
    clrn = 2'b11;
    idle_cycle();

    do_op(0, 1'b0, 2'd2, 1'b0, 32'h50, 32'd0, 1'b0, lat, rd, mis);
    chk("lw50_latency", lat, 3);
    chk("lw50_rdata", rd, 32'h0000_00a3);
    chk("lw50_misalign", {31'd0, mis}, 32'd0);

    do_op(0, 1'b1, 2'd0, 1'b0, 32'h5d, 32'h0000_00ff, 1'b0, lat, rd, mis);
    chk("sb5d_latency", lat, 4);
    chk("sb5d_m_addr", last_wa[0], 32'h5c);
    chk("sb5d_m_datain", last_wd[0], 32'h0000_ff15);
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h5c, 32'd0, 1'b0, lat, rd, mis);
    chk("lw5c_rdata", rd, 32'h0000_ff15);

    do_op(0, 1'b0, 2'd0, 1'b1, 32'h50, 32'd0, 1'b0, lat, rd, mis);
    chk("lb50_sext", rd, 32'hffff_ffa3);
    do_op(0, 1'b0, 2'd0, 1'b0, 32'h50, 32'd0, 1'b1, lat, rd, mis);
    chk("lb50_zext", rd, 32'h0000_00a3);

    do_op(0, 1'b1, 2'd2, 1'b0, 32'h52, 32'h1234_5678, 1'b0, lat, rd, mis);
    chk("sw52_latency", lat, 2);
    chk("sw52_misalign", {31'd0, mis}, 32'd1);
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h50, 32'd0, 1'b0, lat, rd, mis);
    chk("lw50_after_fault", rd, 32'h0000_00a3);

    // Half store to 0x58 aborted by reset while the read is in flight.
    req[0] = 1'b1; wr[0] = 1'b1; size[0] = 2'd1; sext[0] = 1'b0; addr[0] = 32'h58; wdata[0] = 32'h0000_beef;
    @(negedge clk);
    sample();
    @(posedge clk);
    #3;
    clrn[0] = 1'b0;
    @(negedge clk);
    sample();
    reset_outputs_zero(0);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    @(negedge clk);
    sample();
    reset_outputs_zero(0);
    @(posedge clk);
    #1;
    clrn[0] = 1'b1;
    repeat (3) idle_cycle();
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h58, 32'd0, 1'b0, lat, rd, mis);
    chk("lw58_after_reset", rd, 32'h0000_0079);

    do_op(1, 1'b0, 2'd1, 1'b0, 32'h54, 32'd0, 1'b0, lat, rd, mis);
    chk("w2_lh54_latency", lat, 5);
    chk("w2_lh54_rdata", rd, 32'h0000_0027);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        do_op(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              {24'd0, 8'($urandom)}, $urandom, $urandom_range(0, 3) == 0, lat, rd, mis);
        repeat ($urandom_range(0, 2)) idle_cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
